// File: rtl/core_seq.sv
// ----------------------------------------------------------------------------
// core_seq : multi-cycle instruction sequencer for a simple in-order core.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and
// drives the datapath strobes. It can park in HALTED between instructions.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   mem_ack    : memory completed current request; read data valid this cycle
//   halt       : stop issuing fetches at the next instruction boundary
//   is_load .. is_fencei, rd_w : decode flags from the instruction register
//   mem_req    : memory request active
//   mem_we     : request is a write
//   addr_sel   : memory address source, 0 = PC, 1 = ALU result
//   ir_we      : load instruction register from memory read data
//   pc_we      : commit next PC
//   rf_we      : register-file write enable
//   retire     : one-cycle pulse, instruction completed
//   state      : current FSM state encoding
//   instret    : retired-instruction count (wraps modulo 2^CNT_W)
// ----------------------------------------------------------------------------
module core_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_ack,
   input  logic             halt,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             is_branch,
   input  logic             is_jmp,
   input  logic             rd_w,
   input  logic             is_fence,
   input  logic             is_fencei,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic             rf_we,
   output logic             retire,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALTED = 3'd5
   } state_t;

   state_t state_q;
   state_t state_d;
   state_t boundary_nxt;
   logic   retire_raw;

   // Branch/jump/fence flags only steer the datapath; the sequencer treats
   // every non-memory, non-writeback instruction identically.
   logic unused_flags;
   assign unused_flags = ^{is_branch, is_jmp, is_fence, is_fencei};

   // Instruction boundary: park in HALTED if a halt is pending.
   assign boundary_nxt = halt ? HALTED : FETCH;

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      rf_we      = 1'b0;
      retire_raw = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_we   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: state_d = EXEC;
         EXEC: begin
            if (is_load || is_store) begin
               state_d = MEM;
            end else if (rd_w) begin
               state_d = WB;
            end else begin
               pc_we      = 1'b1;
               retire_raw = 1'b1;
               state_d    = boundary_nxt;
            end
         end
         MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = is_store;
            if (mem_ack) begin
               if (is_store) begin
                  pc_we      = 1'b1;
                  retire_raw = 1'b1;
                  state_d    = boundary_nxt;
               end else begin
                  state_d = WB;
               end
            end
         end
         WB: begin
            rf_we      = rd_w;
            pc_we      = 1'b1;
            retire_raw = 1'b1;
            state_d    = boundary_nxt;
         end
         HALTED: begin
            if (!halt) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // A reset edge discards the instruction in flight, so it must not count.
   assign retire = retire_raw & ~rst;
   assign state  = state_q;

   // State / counter register boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         instret <= '0;
      end else begin
         state_q <= state_d;
         if (retire) instret <= instret + 1'b1;
      end
   end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter XLEN, default 32: datapath width; carried for consistency, no port depends on it.
REQ-002 Parameter CNT_W, default 64: width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mem_ack  input  1  memory has completed the current request this cycle; read data valid this cycle.
REQ-006 halt  input  1  request to stop issuing instruction fetches.
REQ-007 is_load, is_store, is_branch, is_jmp, rd_w, is_fence, is_fencei  input  1 each  decode flags from the instruction register.
REQ-008 mem_req  output  1  memory request active.
REQ-009 mem_we  output  1  request is a write.
REQ-010 addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-011 ir_we  output  1  load instruction register from memory read data.
REQ-012 pc_we  output  1  commit next PC.
REQ-013 rf_we  output  1  register-file write enable.
REQ-014 retire  output  1  one-cycle pulse, instruction completed.
REQ-015 state  output  3  current FSM state encoding.
REQ-016 instret  output  CNT_W  retired-instruction count.

Function
REQ-017 States and encodings SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5; codes 6-7 SHALL go to FETCH next cycle with all strobes low.
REQ-018 All strobe outputs SHALL be combinational from state, decode flags and mem_ack; state and instret SHALL be registered.
REQ-019 FETCH: mem_req=1, addr_sel=0, mem_we=0; stay while mem_ack=0; on mem_ack=1, ir_we=1 that cycle, next DECODE.
REQ-020 DECODE: all strobes 0; next EXEC unconditionally (one cycle for decode and register read).
REQ-021 EXEC, is_load|is_store: next MEM, no strobes.
REQ-022 EXEC, neither load nor store, rd_w=1 (ALU, LUI, AUIPC, JAL, JALR): next WB, no strobes.
REQ-023 EXEC, neither load nor store, rd_w=0 (branch, fence, fence.i): pc_we=1, retire=1, next FETCH/HALTED per REQ-027.
REQ-024 MEM: mem_req=1, addr_sel=1, mem_we=is_store; hold until mem_ack; on ack with is_store: pc_we=1, retire=1, next FETCH/HALTED; on ack with is_load: next WB.
REQ-025 WB: rf_we=rd_w, pc_we=1, retire=1; next FETCH/HALTED.
REQ-026 mem_req, mem_we and addr_sel SHALL remain stable while waiting for mem_ack; mem_ack SHALL be ignored in states other than FETCH and MEM.
REQ-027 On every transition toward FETCH (REQ-023/024/025), next state SHALL be HALTED if halt=1 that cycle, else FETCH.
REQ-028 HALTED: all strobes 0; next FETCH when halt=0; HALTED SHALL never be entered mid-instruction.
REQ-029 Decode flags SHALL be treated as stable from DECODE through the instruction's final state; is_fence/is_fencei SHALL behave as no-ops per REQ-023.
REQ-030 instret SHALL increment by 1 in each cycle retire=1, modulo 2^CNT_W (all-ones wraps to 0).
REQ-031 pc_we, rf_we, ir_we SHALL never be asserted outside the cases above; at most one retire per instruction.

Reset
REQ-032 rst=1 at a clock edge SHALL set state=FETCH and instret=0, overriding all other transitions, including mid-MEM with a request outstanding; memory side is reset by the same rst.
REQ-033 During the reset cycle strobe outputs follow state FETCH after the edge; retire SHALL be 0 in the cycle rst is sampled.

Verification
REQ-034 ALU op (rd_w=1), mem_ack high every cycle -> states 0,1,2,4; ir_we in cycle 1, rf_we/pc_we/retire in cycle 4; instret 0->1.
REQ-035 Load, mem_ack delayed 2 cycles in FETCH and 3 in MEM -> mem_req held with addr_sel 0 then 1, mem_we=0; 10 cycles total; retire only in WB.
REQ-036 Store with immediate ack -> states 0,1,2,3; mem_we=1 in MEM; rf_we never 1; retire in MEM cycle.
REQ-037 Branch (rd_w=0) -> states 0,1,2; pc_we/retire in EXEC; next state FETCH; halt=1 in that cycle -> HALTED instead, stays while halt=1, FETCH one cycle after halt drops.
REQ-038 rst pulse while in MEM waiting for ack -> state=0, instret=0 next cycle; no retire.
REQ-039 CNT_W=4, 16 back-to-back ALU retires -> instret 15 then wraps to 0.
